// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder and its pin synchronizer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned num_regs);
    return {{(32-ADDR_W){1'b0}}, a} < num_regs;
  endfunction

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pins plus the register-write notification bus of the responder.
interface spi_reg_responder_if;
  import spi_pkg::*;

  logic                spi_clk;
  logic                mosi;
  logic                cs;
  logic                miso;
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [BYTE_W-1:0]   wr_data;
  logic                frame_err;

  modport master (
    output spi_clk, mosi, cs,
    input  miso, wr_valid, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  spi_clk, mosi, cs,
    output miso, wr_valid, wr_addr, wr_data, frame_err
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Oversampling synchronizers for spi_clk/mosi/cs with edge detection on spi_clk and cs.
module spi_pin_sync
  import spi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic spi_clk_i,
  input  logic mosi_i,
  input  logic cs_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic mosi_o,
  output logic cs_o,
  output logic cs_rise_o,
  output logic cs_fall_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      cs_q        <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign mosi_o      = mosi_q[SYNC_STAGES-1];
  assign cs_o        = cs_q[SYNC_STAGES-1];
  assign cs_rise_o   = cs_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign cs_fall_o   = ~cs_q[SYNC_STAGES-1] & cs_prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing NUM_REGS byte registers: {rw, addr[6:0]} then data, MSB first.
// Optional burst mode (address auto-increment per data byte) via `define SPI_REG_AUTO_INC_EN.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int unsigned        NUM_REGS  = 8,
  parameter logic [BYTE_W-1:0]  RESET_VAL = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  spi_reg_responder_if.slave           bus,
  output logic [NUM_REGS*BYTE_W-1:0]   reg_out
);

  logic sclk_rise, sclk_fall, mosi_s, cs_s, cs_rise, cs_fall;

  spi_pin_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .spi_clk_i   (bus.spi_clk),
    .mosi_i      (bus.mosi),
    .cs_i        (bus.cs),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .mosi_o      (mosi_s),
    .cs_o        (cs_s),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [BYTE_W-1:0]   tx_q, tx_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_err_q, frame_err_d;
  logic [BYTE_W-1:0]   regs_q [NUM_REGS];
  logic [BYTE_W-1:0]   rx_shifted;

  function automatic logic [BYTE_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
    logic [BYTE_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) v = regs_q[i];
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    rx_shifted  = {rx_q[BYTE_W-2:0], mosi_s};

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = '0;
          rw_d      = 1'b0;
          addr_d    = '0;
        end
      end

      CMD, DATA: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (!cs_s) begin
          if (sclk_rise) begin
            rx_d      = rx_shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == CMD) begin
                state_d = DATA;
                rw_d    = rx_shifted[CMD_RW_BIT];
                addr_d  = rx_shifted[ADDR_W-1:0];
                tx_d    = rx_shifted[CMD_RW_BIT] ? read_reg(rx_shifted[ADDR_W-1:0]) : '0;
              end else begin
                if (!rw_q) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = addr_q;
                  wr_data_d  = rx_shifted;
                end
`ifdef SPI_REG_AUTO_INC_EN
                addr_d = addr_q + 7'd1;
                if (rw_q) tx_d = read_reg(addr_q + 7'd1);
`else
                state_d = DONE;
`endif
              end
            end
          // The falling edge that ends the command byte (bit_cnt 0) must not shift:
          // the MSB is already presented from the load on the 8th rising edge.
          end else if (sclk_fall && (state_q == DATA) && rw_q && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[BYTE_W-2:0], 1'b0};
          end
        end
      end

      DONE: begin
        if (cs_rise) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Register file commits one cycle after the wr_valid pulse; out-of-range addresses match nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_valid_q && addr_ok(wr_addr_q, NUM_REGS)) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr_q == ADDR_W'(i)) regs_q[i] <= wr_data_q;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[i*BYTE_W +: BYTE_W] = regs_q[i];
  end

  assign bus.miso      = ((state_q == DATA) && rw_q && !cs_s) ? tx_q[BYTE_W-1] : 1'b0;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed, table-driven bench for spi_reg_responder (NUM_REGS=8, RESET_VAL=8'hA5).
module tb_spi_reg_responder;

  localparam int unsigned HALF = 80;

  logic        clk;
  logic        reset;
  logic [63:0] reg_out;

  spi_reg_responder_if bus ();

  spi_reg_responder #(.NUM_REGS(8), .RESET_VAL(8'hA5)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .reg_out (reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned wv_cnt = 0;
  int unsigned fe_cnt = 0;
  logic [6:0]  last_waddr = '0;
  logic [7:0]  last_wdata = '0;

  always @(negedge clk) begin
    if (bus.wr_valid) begin
      wv_cnt     = wv_cnt + 1;
      last_waddr = bus.wr_addr;
      last_wdata = bus.wr_data;
    end
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xbit(input logic b, output logic r);
    bus.mosi = b;
    #HALF;
    r = bus.miso;
    bus.spi_clk = 1'b1;
    #HALF;
    bus.spi_clk = 1'b0;
  endtask

  // bytes are packed MSB-first: byte k sits at [31-8k -: 8]; the last byte sends last_bits bits
  task automatic frame(input logic [31:0] bytes, input int unsigned nbytes,
                       input int unsigned last_bits, output logic [31:0] rx);
    logic r;
    rx = '0;
    bus.cs = 1'b0;
    #HALF;
    for (int unsigned k = 0; k < nbytes; k++) begin
      int unsigned nb;
      nb = (k == nbytes - 1) ? last_bits : 8;
      for (int unsigned j = 0; j < nb; j++) begin
        int unsigned idx;
        idx = 31 - 8*k - j;
        xbit(bytes[idx], r);
        rx[idx] = r;
      end
    end
    #HALF;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    #(HALF*3);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [7:0]  dat;
    int unsigned nbytes;
    int unsigned last_bits;
    logic        chk_rx;
    logic [7:0]  exp_rx;
    int unsigned exp_wv;
    logic [6:0]  exp_waddr;
    logic [7:0]  exp_wdata;
    int unsigned exp_fe;
    logic [63:0] exp_regs;
  } vec_t;

  function automatic vec_t mk(string name, logic [7:0] cmd, logic [7:0] dat, int unsigned nbytes,
                              int unsigned last_bits, logic chk_rx, logic [7:0] exp_rx,
                              int unsigned exp_wv, logic [6:0] exp_waddr, logic [7:0] exp_wdata,
                              int unsigned exp_fe, logic [63:0] exp_regs);
    vec_t v;
    v.name = name; v.cmd = cmd; v.dat = dat; v.nbytes = nbytes; v.last_bits = last_bits;
    v.chk_rx = chk_rx; v.exp_rx = exp_rx; v.exp_wv = exp_wv; v.exp_waddr = exp_waddr;
    v.exp_wdata = exp_wdata; v.exp_fe = exp_fe; v.exp_regs = exp_regs;
    return v;
  endfunction

  localparam logic [63:0] R0 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] R1 = 64'hA5A5_A5A5_A55A_A5A5;
  localparam logic [63:0] R2 = 64'hC3A5_A5A5_A55A_A5A5;
`ifdef SPI_REG_AUTO_INC_EN
  localparam logic [63:0] R3       = 64'h2211_A5A5_A55A_A5A5;
  localparam int unsigned BURST_WV = 3;
  localparam logic [6:0]  BURST_WA = 7'd8;
  localparam logic [7:0]  BURST_WD = 8'h33;
  localparam logic [15:0] BURST_RD = 16'h1122;
`else
  localparam logic [63:0] R3       = 64'hC311_A5A5_A55A_A5A5;
  localparam int unsigned BURST_WV = 1;
  localparam logic [6:0]  BURST_WA = 7'd6;
  localparam logic [7:0]  BURST_WD = 8'h11;
  localparam logic [15:0] BURST_RD = 16'h1100;
`endif

  vec_t vecs [11];

  initial begin
    logic [31:0] rx;
    int unsigned wv0, fe0;
    logic        r;

    vecs[0]  = mk("rd0_reset",  8'h80, 8'h00, 2, 8, 1'b1, 8'hA5, 0, 7'd0,  8'h00, 0, R0);
    vecs[1]  = mk("wr2",        8'h02, 8'h5A, 2, 8, 1'b0, 8'h00, 1, 7'd2,  8'h5A, 0, R1);
    vecs[2]  = mk("rd2",        8'h82, 8'h00, 2, 8, 1'b1, 8'h5A, 0, 7'd0,  8'h00, 0, R1);
    vecs[3]  = mk("wr_oor",     8'h0A, 8'hFF, 2, 8, 1'b0, 8'h00, 1, 7'd10, 8'hFF, 0, R1);
    vecs[4]  = mk("rd_oor",     8'h8A, 8'h00, 2, 8, 1'b1, 8'h00, 0, 7'd0,  8'h00, 0, R1);
    vecs[5]  = mk("abort_data", 8'h01, 8'h3C, 2, 5, 1'b0, 8'h00, 0, 7'd0,  8'h00, 1, R1);
    vecs[6]  = mk("abort_cmd",  8'h03, 8'h00, 1, 3, 1'b0, 8'h00, 0, 7'd0,  8'h00, 1, R1);
    vecs[7]  = mk("cmd_only",   8'h03, 8'h00, 1, 8, 1'b0, 8'h00, 0, 7'd0,  8'h00, 0, R1);
    vecs[8]  = mk("wr7",        8'h07, 8'hC3, 2, 8, 1'b0, 8'h00, 1, 7'd7,  8'hC3, 0, R2);
    vecs[9]  = mk("rd7",        8'h87, 8'h00, 2, 8, 1'b1, 8'hC3, 0, 7'd0,  8'h00, 0, R2);
    vecs[10] = mk("rd1",        8'h81, 8'h00, 2, 8, 1'b1, 8'hA5, 0, 7'd0,  8'h00, 0, R2);

    reset       = 1'b1;
    bus.spi_clk = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    #40;
    reset = 1'b0;
    #40;
    chk("rst_miso",     64'(bus.miso),      64'd0);
    chk("rst_wr_valid", 64'(bus.wr_valid),  64'd0);
    chk("rst_frame_err",64'(bus.frame_err), 64'd0);
    chk("rst_wr_addr",  64'(bus.wr_addr),   64'd0);
    chk("rst_wr_data",  64'(bus.wr_data),   64'd0);
    chk("rst_reg_out",  reg_out,            R0);

    for (int unsigned i = 0; i < 11; i++) begin
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      frame({vecs[i].cmd, vecs[i].dat, 16'h0000}, vecs[i].nbytes, vecs[i].last_bits, rx);
      if (vecs[i].chk_rx) chk({vecs[i].name, "_miso"}, 64'(rx[23:16]), 64'(vecs[i].exp_rx));
      chk({vecs[i].name, "_wv"}, 64'(wv_cnt - wv0), 64'(vecs[i].exp_wv));
      if (vecs[i].exp_wv != 0) begin
        chk({vecs[i].name, "_waddr"}, 64'(last_waddr), 64'(vecs[i].exp_waddr));
        chk({vecs[i].name, "_wdata"}, 64'(last_wdata), 64'(vecs[i].exp_wdata));
      end
      chk({vecs[i].name, "_ferr"}, 64'(fe_cnt - fe0), 64'(vecs[i].exp_fe));
      chk({vecs[i].name, "_regs"}, reg_out, vecs[i].exp_regs);
    end

    // multi-byte frame: burst write then burst read starting at reg 6
    wv0 = wv_cnt;
    frame(32'h0611_2233, 4, 8, rx);
    chk("burst_wv",    64'(wv_cnt - wv0), 64'(BURST_WV));
    chk("burst_waddr", 64'(last_waddr),   64'(BURST_WA));
    chk("burst_wdata", 64'(last_wdata),   64'(BURST_WD));
    chk("burst_regs",  reg_out,           R3);
    frame(32'h8600_0000, 3, 8, rx);
    chk("burst_rd",    64'(rx[23:8]),     64'(BURST_RD));

    // reset during data bit 4 of a read of reg 2 (0x5A: bit 4 is 1)
    bus.cs = 1'b0;
    #HALF;
    for (int unsigned j = 0; j < 8; j++) begin
      logic [7:0] c;
      c = 8'h82;
      xbit(c[7-j], r);
    end
    for (int unsigned j = 0; j < 4; j++) xbit(1'b0, r);
    #40;
    chk("midrd_miso_before", 64'(bus.miso), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrd_miso_reset",  64'(bus.miso), 64'd0);
    chk("midrd_regs_reset",  reg_out,       R0);
    #9;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    #40;
    reset = 1'b0;
    #200;
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    frame(32'h8200_0000, 2, 8, rx);
    chk("post_rst_rd2",  64'(rx[23:16]),   64'hA5);
    frame(32'h0596_0000, 2, 8, rx);
    frame(32'h8500_0000, 2, 8, rx);
    chk("post_rst_rd5",  64'(rx[23:16]),   64'h96);
    chk("post_rst_wv",   64'(wv_cnt - wv0), 64'd1);
    chk("post_rst_ferr", 64'(fe_cnt - fe0), 64'd0);
    chk("post_rst_regs", reg_out,          64'hA5A5_96A5_A5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0) that exposes a small register file to an external SPI initiator, MSB first.
- Each frame carries a command byte {rw, addr[6:0]} followed by one data byte.
  - rw=0 writes that byte to the register file.
  - rw=1 shifts the register contents out on miso.
- Sits beside the LED/button test logic so that initiator-written values can drive LEDs and status can be read back.
- Oversamples the SPI pins with the system clock; no logic runs in the spi_clk domain.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (1..128); valid addresses are 0..NUM_REGS-1.
- RESET_VAL, 8'h00, reset value loaded into every register.

Ports:
- clk  input  1  system clock; spi_clk must be no faster than clk/8.
- reset  input  1  asynchronous, active-high reset.
- spi_clk  input  1  SPI serial clock from the initiator; idles low.
- mosi  input  1  serial data from the initiator.
- cs  input  1  chip select, active low.
- miso  output  1  serial data to the initiator; driven 0 when not transmitting (never tri-stated).
- reg_out  output  NUM_REGS*8  flattened register file; register i occupies bits [8i+7:8i].
- wr_valid  output  1  one-clk pulse when a register write commits.
- wr_addr  output  7  address of the committed write.
- wr_data  output  8  data of the committed write.
- frame_err  output  1  one-clk pulse when cs rises mid-byte.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - all registers to RESET_VAL;
  - miso, wr_valid, frame_err, wr_addr and wr_data to 0;
  - state to IDLE;
  - all synchronizer flops to their idle values (spi_clk 0, cs 1, mosi 0).
- Input synchronization:
  - spi_clk, mosi and cs each pass through a 2-flop synchronizer.
  - Edges are detected from the synchronized spi_clk and its previous value.
- Bit timing:
  - mosi is sampled on the synchronized rising edge.
  - miso is updated on the synchronized falling edge.
  - Input latency is 3 clk cycles from pin to detected edge.
- States:
  - IDLE -> CMD when synchronized cs falls. Clears the bit counter and shift registers.
  - CMD: shift in 8 bits. On the 8th rising edge, latch rw and addr, then go to DATA.
    - If rw=1, load tx_shift with reg[addr] in the same cycle. Out-of-range addr loads 8'h00.
    - miso then presents tx_shift[7] immediately, so the MSB is valid before the first data-byte rising edge.
  - DATA, read: on each falling edge, shift tx_shift left with 0 fill. On the 8th rising edge go to DONE.
  - DATA, write: shift mosi in. On the 8th rising edge, do all of the following in one cycle, then go to DONE:
    - if addr < NUM_REGS, write reg[addr];
    - pulse wr_valid with wr_addr and wr_data.
  - DONE: ignore further bits (miso=0, no writes) until cs rises, then go to IDLE.
- Out-of-range write: wr_valid still pulses with wr_addr = addr, but no register changes.
- cs rising in CMD or DATA with 1..7 bits of the current byte received:
  - discard the partial byte with no write;
  - pulse frame_err for 1 cycle;
  - go to IDLE.
- cs rising on a byte boundary (0 bits pending) returns to IDLE with no frame_err.
- cs rising and a spi_clk edge detected in the same cycle: cs wins and the edge is ignored.
- cs high: miso=0 and spi_clk edges are ignored.
- Reset mid-frame: immediate return to IDLE. A transfer in progress is lost, and registers revert to RESET_VAL.
- reg_out reflects a register write on the cycle after wr_valid.

Optional Feature:
- Macro: SPI_REG_AUTO_INC_EN.
- Defined (burst mode):
  - after each completed data byte, the FSM stays in DATA instead of DONE;
  - addr increments modulo 128;
  - reads reload tx_shift from the new address on the 8th rising edge;
  - writes commit per byte with one wr_valid pulse per byte;
  - out-of-range rules apply per byte.
- Undefined: a single data byte per frame; DONE behaviour as above.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding (IDLE, CMD, DATA, DONE);
  - CMD_RW_BIT=7;
  - ADDR_W=7 and BYTE_W=8;
  - SYNC_STAGES=2.
- One natural sub-module: spi_pin_sync. It holds the 2-flop synchronizers plus rise/fall detect for spi_clk and synchronized cs/mosi, and is reusable by the existing initiator-side test logic.

Test Plan:
- Write then read:
  - Frame {0x02, 0x5A} -> wr_valid pulse with wr_addr=2, wr_data=0x5A; reg_out[23:16]=0x5A.
  - Next frame {0x82, 0x00} -> miso bits 0,1,0,1,1,0,1,0 on the data byte.
- Reset values: read addr 0 after reset with RESET_VAL=0xA5 -> miso returns 0xA5; wr_valid never pulses.
- Out of range (NUM_REGS=8):
  - Write {0x0A, 0xFF} -> wr_valid pulses with wr_addr=10, and reg_out is unchanged.
  - Read {0x8A} -> returns 0x00.
- Aborted frame: cs rises after 5 bits of the data byte in write {0x01, 0x3C} -> frame_err pulses once, no wr_valid, and reg 1 is unchanged.
- Reset mid-read: assert reset during bit 4 of the read data -> miso=0 immediately and state is IDLE; the next full frame completes correctly.
- Auto-increment (SPI_REG_AUTO_INC_EN defined): frame {0x06, 0x11, 0x22, 0x33} with NUM_REGS=8 ->
  - regs 6=0x11 and 7=0x22;
  - the third data byte's wr_valid shows addr 8 with no change;
  - 3 wr_valid pulses in total.
  - With the macro undefined, only reg 6 is written.
